// File: rtl/id_ex_stage_reg.sv
// ID/EX pipeline register with embedded load-use hazard detection, branch flush,
// downstream hold and a saturating count of inserted bubbles.
module id_ex_stage_reg #(
    parameter int unsigned XLEN   = 32,
    parameter int unsigned REG_AW = 5,
    parameter int unsigned CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              id_valid,
    input  logic [XLEN-1:0]   id_pc,
    input  logic [XLEN-1:0]   id_rs1_data,
    input  logic [XLEN-1:0]   id_rs2_data,
    input  logic [XLEN-1:0]   id_imm,
    input  logic [REG_AW-1:0] id_rs1,
    input  logic [REG_AW-1:0] id_rs2,
    input  logic [REG_AW-1:0] id_rd,
    input  logic [2:0]        id_funct3,
    input  logic              id_funct7b5,
    input  logic [1:0]        id_ALUop,
    input  logic              id_ALUsrc,
    input  logic              id_MtoR,
    input  logic              id_regwrite,
    input  logic              id_memread,
    input  logic              id_memwrite,
    input  logic              id_branch,
    input  logic              flush,
    input  logic              hold,
    output logic              stall,
    output logic              ex_valid,
    output logic [XLEN-1:0]   ex_pc,
    output logic [XLEN-1:0]   ex_rs1_data,
    output logic [XLEN-1:0]   ex_rs2_data,
    output logic [XLEN-1:0]   ex_imm,
    output logic [REG_AW-1:0] ex_rs1,
    output logic [REG_AW-1:0] ex_rs2,
    output logic [REG_AW-1:0] ex_rd,
    output logic [2:0]        ex_funct3,
    output logic              ex_funct7b5,
    output logic [1:0]        ex_ALUop,
    output logic              ex_ALUsrc,
    output logic              ex_MtoR,
    output logic              ex_regwrite,
    output logic              ex_memread,
    output logic              ex_memwrite,
    output logic              ex_branch,
    output logic [CNT_W-1:0]  bubble_count
);

    // Datapath fields
    logic [XLEN-1:0]   pc_q, pc_d;
    logic [XLEN-1:0]   rs1_data_q, rs1_data_d;
    logic [XLEN-1:0]   rs2_data_q, rs2_data_d;
    logic [XLEN-1:0]   imm_q, imm_d;
    logic [REG_AW-1:0] rs1_q, rs1_d;
    logic [REG_AW-1:0] rs2_q, rs2_d;
    logic [REG_AW-1:0] rd_q, rd_d;
    logic [2:0]        funct3_q, funct3_d;
    logic              funct7b5_q, funct7b5_d;

    // Valid and control fields
    logic              valid_q, valid_d;
    logic [1:0]        aluop_q, aluop_d;
    logic              alusrc_q, alusrc_d;
    logic              mtor_q, mtor_d;
    logic              regwrite_q, regwrite_d;
    logic              memread_q, memread_d;
    logic              memwrite_q, memwrite_d;
    logic              branch_q, branch_d;

    logic [CNT_W-1:0]  count_q, count_d;

    logic load_use;
    logic do_kill;
    logic do_bubble;
    logic do_capture;

    // Both sources are compared regardless of opcode; a spurious match only costs a bubble.
    assign load_use = valid_q & memread_q & (rd_q != '0) & id_valid
                    & ((rd_q == id_rs1) | (rd_q == id_rs2));

    assign stall = (load_use & ~flush) | hold;

    // Priority: flush > hold > load-use bubble > capture.
    assign do_bubble  = ~flush & ~hold & load_use;
    assign do_kill    = flush | do_bubble;
    assign do_capture = ~flush & ~hold & ~load_use;

    always_comb begin
        pc_d       = pc_q;
        rs1_data_d = rs1_data_q;
        rs2_data_d = rs2_data_q;
        imm_d      = imm_q;
        rs1_d      = rs1_q;
        rs2_d      = rs2_q;
        rd_d       = rd_q;
        funct3_d   = funct3_q;
        funct7b5_d = funct7b5_q;
        if (do_capture) begin
            pc_d       = id_pc;
            rs1_data_d = id_rs1_data;
            rs2_data_d = id_rs2_data;
            imm_d      = id_imm;
            rs1_d      = id_rs1;
            rs2_d      = id_rs2;
            rd_d       = id_rd;
            funct3_d   = id_funct3;
            funct7b5_d = id_funct7b5;
        end
    end

    always_comb begin
        valid_d    = valid_q;
        aluop_d    = aluop_q;
        alusrc_d   = alusrc_q;
        mtor_d     = mtor_q;
        regwrite_d = regwrite_q;
        memread_d  = memread_q;
        memwrite_d = memwrite_q;
        branch_d   = branch_q;
        if (do_kill) begin
            valid_d    = 1'b0;
            aluop_d    = 2'b00;
            alusrc_d   = 1'b0;
            mtor_d     = 1'b0;
            regwrite_d = 1'b0;
            memread_d  = 1'b0;
            memwrite_d = 1'b0;
            branch_d   = 1'b0;
        end else if (do_capture) begin
            // An invalid slot never carries control into EX.
            valid_d    = id_valid;
            aluop_d    = id_valid ? id_ALUop : 2'b00;
            alusrc_d   = id_valid & id_ALUsrc;
            mtor_d     = id_valid & id_MtoR;
            regwrite_d = id_valid & id_regwrite;
            memread_d  = id_valid & id_memread;
            memwrite_d = id_valid & id_memwrite;
            branch_d   = id_valid & id_branch;
        end
    end

    always_comb begin
        count_d = count_q;
        if (do_bubble && (count_q != {CNT_W{1'b1}})) begin
            count_d = count_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc_q       <= '0;
            rs1_data_q <= '0;
            rs2_data_q <= '0;
            imm_q      <= '0;
            rs1_q      <= '0;
            rs2_q      <= '0;
            rd_q       <= '0;
            funct3_q   <= '0;
            funct7b5_q <= 1'b0;
            valid_q    <= 1'b0;
            aluop_q    <= '0;
            alusrc_q   <= 1'b0;
            mtor_q     <= 1'b0;
            regwrite_q <= 1'b0;
            memread_q  <= 1'b0;
            memwrite_q <= 1'b0;
            branch_q   <= 1'b0;
            count_q    <= '0;
        end else begin
            pc_q       <= pc_d;
            rs1_data_q <= rs1_data_d;
            rs2_data_q <= rs2_data_d;
            imm_q      <= imm_d;
            rs1_q      <= rs1_d;
            rs2_q      <= rs2_d;
            rd_q       <= rd_d;
            funct3_q   <= funct3_d;
            funct7b5_q <= funct7b5_d;
            valid_q    <= valid_d;
            aluop_q    <= aluop_d;
            alusrc_q   <= alusrc_d;
            mtor_q     <= mtor_d;
            regwrite_q <= regwrite_d;
            memread_q  <= memread_d;
            memwrite_q <= memwrite_d;
            branch_q   <= branch_d;
            count_q    <= count_d;
        end
    end

    assign ex_valid     = valid_q;
    assign ex_pc        = pc_q;
    assign ex_rs1_data  = rs1_data_q;
    assign ex_rs2_data  = rs2_data_q;
    assign ex_imm       = imm_q;
    assign ex_rs1       = rs1_q;
    assign ex_rs2       = rs2_q;
    assign ex_rd        = rd_q;
    assign ex_funct3    = funct3_q;
    assign ex_funct7b5  = funct7b5_q;
    assign ex_ALUop     = aluop_q;
    assign ex_ALUsrc    = alusrc_q;
    assign ex_MtoR      = mtor_q;
    assign ex_regwrite  = regwrite_q;
    assign ex_memread   = memread_q;
    assign ex_memwrite  = memwrite_q;
    assign ex_branch    = branch_q;
    assign bubble_count = count_q;

endmodule

// File: tb/tb_id_ex_stage_reg.sv
// Bench for id_ex_stage_reg: directed hazard scenarios plus randomized traffic
// checked against a slot-level reference model of the ID/EX register.
module tb_id_ex_stage_reg;

    localparam int unsigned CW = 8;  // narrow counter so saturation is reachable quickly

    typedef struct packed {
        logic        valid;
        logic [31:0] pc;
        logic [31:0] rs1d;
        logic [31:0] rs2d;
        logic [31:0] imm;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [4:0]  rd;
        logic [2:0]  f3;
        logic        f7;
        logic [1:0]  aluop;
        logic        alusrc;
        logic        mtor;
        logic        regwrite;
        logic        memread;
        logic        memwrite;
        logic        branch;
    } slot_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic flush = 1'b0;
    logic hold = 1'b0;
    slot_t id_s = '0;
    slot_t dut_s;

    logic        stall;
    logic        ex_valid;
    logic [31:0] ex_pc, ex_rs1_data, ex_rs2_data, ex_imm;
    logic [4:0]  ex_rs1, ex_rs2, ex_rd;
    logic [2:0]  ex_funct3;
    logic        ex_funct7b5;
    logic [1:0]  ex_ALUop;
    logic        ex_ALUsrc, ex_MtoR, ex_regwrite, ex_memread, ex_memwrite, ex_branch;
    logic [CW-1:0] bubble_count;

    int checks = 0;
    int errors = 0;

    slot_t m_ex = '0;
    int    m_cnt = 0;

    always #5 clk = ~clk;

    id_ex_stage_reg #(.XLEN(32), .REG_AW(5), .CNT_W(CW)) dut (
        .clk(clk), .rst(rst),
        .id_valid(id_s.valid), .id_pc(id_s.pc), .id_rs1_data(id_s.rs1d),
        .id_rs2_data(id_s.rs2d), .id_imm(id_s.imm), .id_rs1(id_s.rs1), .id_rs2(id_s.rs2),
        .id_rd(id_s.rd), .id_funct3(id_s.f3), .id_funct7b5(id_s.f7), .id_ALUop(id_s.aluop),
        .id_ALUsrc(id_s.alusrc), .id_MtoR(id_s.mtor), .id_regwrite(id_s.regwrite),
        .id_memread(id_s.memread), .id_memwrite(id_s.memwrite), .id_branch(id_s.branch),
        .flush(flush), .hold(hold), .stall(stall),
        .ex_valid(ex_valid), .ex_pc(ex_pc), .ex_rs1_data(ex_rs1_data),
        .ex_rs2_data(ex_rs2_data), .ex_imm(ex_imm), .ex_rs1(ex_rs1), .ex_rs2(ex_rs2),
        .ex_rd(ex_rd), .ex_funct3(ex_funct3), .ex_funct7b5(ex_funct7b5),
        .ex_ALUop(ex_ALUop), .ex_ALUsrc(ex_ALUsrc), .ex_MtoR(ex_MtoR),
        .ex_regwrite(ex_regwrite), .ex_memread(ex_memread), .ex_memwrite(ex_memwrite),
        .ex_branch(ex_branch), .bubble_count(bubble_count)
    );

    assign dut_s = {ex_valid, ex_pc, ex_rs1_data, ex_rs2_data, ex_imm, ex_rs1, ex_rs2, ex_rd,
                    ex_funct3, ex_funct7b5, ex_ALUop, ex_ALUsrc, ex_MtoR, ex_regwrite,
                    ex_memread, ex_memwrite, ex_branch};

    task automatic chk(string tag, logic [159:0] obs, logic [159:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic slot_t kill(slot_t s);
        slot_t k = s;
        k.valid = 1'b0; k.aluop = 2'b00; k.alusrc = 1'b0; k.mtor = 1'b0;
        k.regwrite = 1'b0; k.memread = 1'b0; k.memwrite = 1'b0; k.branch = 1'b0;
        return k;
    endfunction

    // A consumer in ID depends on a load in EX writing a non-zero register.
    function automatic bit m_load_use();
        return m_ex.valid && m_ex.memread && (m_ex.rd != 5'd0) && id_s.valid &&
               ((m_ex.rd == id_s.rs1) || (m_ex.rd == id_s.rs2));
    endfunction

    function automatic slot_t mk(logic [4:0] rs1, logic [4:0] rs2, logic [4:0] rd,
                                 logic [1:0] aluop, logic alusrc, logic mtor, logic regwrite,
                                 logic memread, logic memwrite);
        slot_t s;
        s.valid = 1'b1; s.pc = $urandom; s.rs1d = $urandom; s.rs2d = $urandom;
        s.imm = $urandom; s.rs1 = rs1; s.rs2 = rs2; s.rd = rd; s.f3 = 3'($urandom);
        s.f7 = 1'($urandom); s.aluop = aluop; s.alusrc = alusrc; s.mtor = mtor;
        s.regwrite = regwrite; s.memread = memread; s.memwrite = memwrite; s.branch = 1'b0;
        return s;
    endfunction

    function automatic slot_t rand_slot();
        slot_t s;
        s = mk(5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
               2'($urandom), 1'($urandom), 1'($urandom), 1'($urandom),
               ($urandom_range(0, 1) == 0), 1'($urandom));
        s.branch = 1'($urandom);
        s.valid = ($urandom_range(0, 3) != 0);
        return s;
    endfunction

    // Check stall before the edge, advance the model across it, then check the register.
    task automatic tick(string tag);
        bit lu;
        #1;
        lu = m_load_use();
        chk({tag, "/stall"}, 160'(stall), 160'((lu && !flush) || hold));
        @(posedge clk);
        if (flush) m_ex = kill(m_ex);
        else if (hold) m_ex = m_ex;
        else if (lu) begin
            m_ex = kill(m_ex);
            if (m_cnt < (1 << CW) - 1) m_cnt++;
        end else m_ex = id_s.valid ? id_s : kill(id_s);
        #1;
        chk({tag, "/ex"}, 160'(dut_s), 160'(m_ex));
        chk({tag, "/cnt"}, 160'(bubble_count), 160'(m_cnt));
    endtask

    initial begin
        slot_t lw5, add6, sw;
        // Power-on reset
        #2;
        chk("rst0_ex", 160'(dut_s), 160'(0));
        chk("rst0_cnt", 160'(bubble_count), 160'(0));
        chk("rst0_stall", 160'(stall), 160'(0));
        #1 rst = 1'b0;
        @(posedge clk); #1;

        // lw x5 then add x6,x5,x7: exactly one bubble
        lw5  = mk(5'd1, 5'd0, 5'd5, 2'b00, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
        add6 = mk(5'd5, 5'd7, 5'd6, 2'b10, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        id_s = lw5;  tick("t2_lw");
        id_s = add6; tick("t2_bub");
        chk("t2_bub_valid", 160'(ex_valid), 160'(0));
        chk("t2_bub_cnt", 160'(bubble_count), 160'(1));
        tick("t2_add");
        chk("t2_aluop", 160'(ex_ALUop), 160'(2'b10));
        chk("t2_regwrite", 160'(ex_regwrite), 160'(1));

        // lw x0 never stalls a consumer of x0
        id_s = mk(5'd1, 5'd0, 5'd0, 2'b00, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0); tick("t3_lw0");
        id_s = mk(5'd0, 5'd0, 5'd6, 2'b10, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0); tick("t3_use");
        chk("t3_cnt", 160'(bubble_count), 160'(1));

        // flush beats load-use
        id_s = lw5; tick("t4_lw");
        id_s = add6; flush = 1'b1;
        #1 chk("t4_stall", 160'(stall), 160'(0));
        tick("t4_flush");
        flush = 1'b0;
        chk("t4_valid", 160'(ex_valid), 160'(0));
        chk("t4_cnt", 160'(bubble_count), 160'(1));

        // hold for three cycles with a store in EX
        sw = mk(5'd2, 5'd3, 5'd0, 2'b00, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
        id_s = sw; tick("t5_sw");
        hold = 1'b1;
        for (int i = 0; i < 3; i++) begin
            id_s = rand_slot();
            tick("t5_hold");
            chk("t5_memwrite", 160'(ex_memwrite), 160'(1));
            chk("t5_alusrc", 160'(ex_ALUsrc), 160'(1));
            chk("t5_stall", 160'(stall), 160'(1));
        end
        hold = 1'b0;

        // Randomized traffic
        for (int i = 0; i < 300; i++) begin
            id_s  = rand_slot();
            flush = ($urandom_range(0, 9) == 0);
            hold  = ($urandom_range(0, 7) == 0);
            tick("rnd");
        end
        flush = 1'b0; hold = 1'b0;

        // Asynchronous reset in the middle of a stall
        id_s = lw5; tick("t1_lw");
        id_s = add6;
        #2 rst = 1'b1;
        #1;
        chk("t1_ex", 160'(dut_s), 160'(0));
        chk("t1_cnt", 160'(bubble_count), 160'(0));
        chk("t1_stall", 160'(stall), 160'(0));
        m_ex = '0; m_cnt = 0;
        #1 rst = 1'b0;
        tick("t1_after");

        // Self-dependent load repeats a bubble every other cycle until saturation
        id_s = mk(5'd5, 5'd5, 5'd5, 2'b00, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
        for (int i = 0; i < 2 * (1 << CW) + 8; i++) tick("t6_sat");
        chk("t6_sat_final", 160'(bubble_count), 160'({CW{1'b1}}));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
